// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: EXE command encodings, NZCV bit positions
// and the status-register update class for each command.
package arm_pkg;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [1:0] SR_N = 2'd3;
  localparam logic [1:0] SR_Z = 2'd2;
  localparam logic [1:0] SR_C = 2'd1;
  localparam logic [1:0] SR_V = 2'd0;

  typedef enum logic [1:0] {
    SR_KEEP = 2'b00,
    SR_NZ   = 2'b01,
    SR_NZCV = 2'b10
  } sr_upd_e;

  // Arithmetic ops own all four flags; logical/move ops only N and Z.
  function automatic sr_upd_e sr_upd_of(input logic [3:0] cmd);
    sr_upd_e upd;
    case (cmd)
      EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC:          upd = SR_NZCV;
      EXE_MOV, EXE_MVN, EXE_AND, EXE_ORR, EXE_EOR: upd = SR_NZ;
      EXE_NOP:                                     upd = SR_KEEP;
      default:                                     upd = SR_KEEP;
    endcase
    return upd;
  endfunction

endpackage

// File: rtl/exe_mem_stage_if.sv
// EXE -> MEM pipeline bundle: EXE-side instruction fields in, registered
// MEM-side fields and the architectural status register out.
interface exe_mem_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
);
  logic                  in_valid;
  logic [3:0]            exe_cmd;
  logic                  s_en;
  logic [DATA_W-1:0]     alu_res;
  logic [3:0]            alu_status;
  logic [DATA_W-1:0]     val_rm;
  logic [REG_ADDR_W-1:0] dest;
  logic                  wb_en;
  logic                  mem_r_en;
  logic                  mem_w_en;

  logic                  out_valid;
  logic [DATA_W-1:0]     alu_res_q;
  logic [DATA_W-1:0]     val_rm_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic                  wb_en_q;
  logic                  mem_r_en_q;
  logic                  mem_w_en_q;
  logic [3:0]            sr_nzcv;
  logic                  sr_c;

  modport master (
    output in_valid, exe_cmd, s_en, alu_res, alu_status, val_rm, dest,
           wb_en, mem_r_en, mem_w_en,
    input  out_valid, alu_res_q, val_rm_q, dest_q, wb_en_q, mem_r_en_q,
           mem_w_en_q, sr_nzcv, sr_c
  );

  modport slave (
    input  in_valid, exe_cmd, s_en, alu_res, alu_status, val_rm, dest,
           wb_en, mem_r_en, mem_w_en,
    output out_valid, alu_res_q, val_rm_q, dest_q, wb_en_q, mem_r_en_q,
           mem_w_en_q, sr_nzcv, sr_c
  );
endinterface

// File: rtl/exe_mem_stage_status_reg.sv
// Architectural NZCV flags register; N,Z follow every write, C,V only when
// the writing instruction is arithmetic.
module status_reg
  import arm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic       upd_cv,
  input  logic [3:0] nzcv_in,
  output logic [3:0] nzcv
);

  logic [3:0] nzcv_r;

  // Flag storage with selective C/V update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nzcv_r <= 4'b0000;
    end else if (we) begin
      nzcv_r[SR_N] <= nzcv_in[SR_N];
      nzcv_r[SR_Z] <= nzcv_in[SR_Z];
      if (upd_cv) begin
        nzcv_r[SR_C] <= nzcv_in[SR_C];
        nzcv_r[SR_V] <= nzcv_in[SR_V];
      end
    end
  end

  assign nzcv = nzcv_r;

endmodule

// File: rtl/exe_mem_stage.sv
// EXE/MEM pipeline register with valid bit, flush/freeze control and the
// NZCV status register that feeds carry back to the ALU.
module exe_mem_stage
  import arm_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           freeze,
  input  logic           flush,
  exe_mem_stage_if.slave bus
);

  logic                  valid_r;
  logic [DATA_W-1:0]     alu_res_r;
  logic [DATA_W-1:0]     val_rm_r;
  logic [REG_ADDR_W-1:0] dest_r;
  logic                  wb_en_r;
  logic                  mem_r_en_r;
  logic                  mem_w_en_r;

  sr_upd_e               sr_upd_s;
  logic                  sr_we_s;
  logic                  sr_upd_cv_s;
  logic [3:0]            sr_nzcv_s;

  // Flag-write decode; flush and freeze both block the write.
  always_comb begin
    sr_upd_s    = sr_upd_of(bus.exe_cmd);
    sr_we_s     = 1'b0;
    sr_upd_cv_s = 1'b0;
    if (bus.s_en && bus.in_valid && !flush && !freeze && (sr_upd_s != SR_KEEP)) begin
      sr_we_s     = 1'b1;
      sr_upd_cv_s = (sr_upd_s == SR_NZCV);
    end else begin
      sr_we_s     = 1'b0;
      sr_upd_cv_s = 1'b0;
    end
  end

  // Pipeline register: flush bubbles the slot, freeze holds everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r    <= 1'b0;
      alu_res_r  <= {DATA_W{1'b0}};
      val_rm_r   <= {DATA_W{1'b0}};
      dest_r     <= {REG_ADDR_W{1'b0}};
      wb_en_r    <= 1'b0;
      mem_r_en_r <= 1'b0;
      mem_w_en_r <= 1'b0;
    end else if (flush) begin
      valid_r    <= 1'b0;
      wb_en_r    <= 1'b0;
      mem_r_en_r <= 1'b0;
      mem_w_en_r <= 1'b0;
    end else if (!freeze) begin
      valid_r    <= bus.in_valid;
      alu_res_r  <= bus.alu_res;
      val_rm_r   <= bus.val_rm;
      dest_r     <= bus.dest;
      wb_en_r    <= bus.wb_en    & bus.in_valid;
      mem_r_en_r <= bus.mem_r_en & bus.in_valid;
      mem_w_en_r <= bus.mem_w_en & bus.in_valid;
    end
  end

  status_reg u_status_reg (
    .clk     (clk),
    .rst     (rst),
    .we      (sr_we_s),
    .upd_cv  (sr_upd_cv_s),
    .nzcv_in (bus.alu_status),
    .nzcv    (sr_nzcv_s)
  );

  assign bus.out_valid  = valid_r;
  assign bus.alu_res_q  = alu_res_r;
  assign bus.val_rm_q   = val_rm_r;
  assign bus.dest_q     = dest_r;
  assign bus.wb_en_q    = wb_en_r;
  assign bus.mem_r_en_q = mem_r_en_r;
  assign bus.mem_w_en_q = mem_w_en_r;
  assign bus.sr_nzcv    = sr_nzcv_s;
  // Carry comes from the flop, never from alu_status, so no ALU loop forms.
  assign bus.sr_c       = sr_nzcv_s[SR_C];

endmodule
